// File: rtl/legv8_pkg.sv
// ============================================================================
// legv8_pkg : shared LEGv8 register-file constants and types
// Rev 1.0
// ============================================================================
`default_nettype none

package legv8_pkg;
  localparam int XLEN    = 64;
  localparam int NREGS   = 32;
  localparam int REG_XZR = 31;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [63:0] xword_t;
endpackage

`default_nettype wire

// File: rtl/legv8_rf_rdport.sv
// ============================================================================
// legv8_rf_rdport : one read port - zero/bypass/storage mux plus busy masking
// Rev 1.0
// ============================================================================
`default_nettype none

module legv8_rf_rdport
  import legv8_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int NUM_REGS = NREGS,
  parameter int ZERO_REG = REG_XZR,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              i_reset,
  input  logic [AW-1:0]     i_rd_addr,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [DATA_W-1:0] i_regs [NUM_REGS],
  input  logic [NUM_REGS-1:0] i_busy,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_busy
);

  localparam logic [AW-1:0] c_ZIDX = AW'(ZERO_REG);

  logic w_zero;
  logic w_hit;

  assign w_zero = (i_rd_addr == c_ZIDX);
  assign w_hit  = i_wr_en && (i_wr_addr == i_rd_addr);

  // A same-cycle write-back both supplies the value and retires the hazard.
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = 1'b0;
    if (!i_reset && !w_zero) begin
      o_rd_data = w_hit ? i_wr_data : i_regs[i_rd_addr];
      o_rd_busy = w_hit ? 1'b0 : i_busy[i_rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/legv8_regfile_sb.sv
// ============================================================================
// legv8_regfile_sb : parametrised register file with bypass, XZR and scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module legv8_regfile_sb
  import legv8_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int NUM_REGS = NREGS,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = REG_XZR,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  localparam logic [AW-1:0] c_ZIDX = AW'(ZERO_REG);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;

  logic w_wr_ok;
  logic w_iss_ok;

  assign w_wr_ok  = wr_en  && (wr_addr  != c_ZIDX);
  assign w_iss_ok = iss_en && (iss_addr != c_ZIDX);

  // Set is assigned after clear so a new producer to the same index wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        r_regs[r] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_regs[wr_addr] <= wr_data;
        r_busy[wr_addr] <= 1'b0;
      end
      if (w_iss_ok) begin
        r_busy[iss_addr] <= 1'b1;
      end
    end
  end

  assign busy_vec = r_busy;

  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      legv8_rf_rdport #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
      ) u_port (
        .i_reset   (reset),
        .i_rd_addr (rd_addr[i*AW +: AW]),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_regs    (r_regs),
        .i_busy    (r_busy),
        .o_rd_data (rd_data[i*DATA_W +: DATA_W]),
        .o_rd_busy (rd_busy[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_legv8_regfile_sb.sv
// ============================================================================
// tb_legv8_regfile_sb : directed checks on default and 32b/16-reg/3-port builds
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_legv8_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // default build: 64b, 32 regs, 2 ports, XZR=31
  logic [9:0]   rd_addr;
  logic [127:0] rd_data;
  logic [1:0]   rd_busy;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         iss_en;
  logic [4:0]   iss_addr;
  logic [31:0]  busy_vec;

  // small build: 32b, 16 regs, 3 ports, zero=15
  logic [11:0]  rd_addr3;
  logic [95:0]  rd_data3;
  logic [2:0]   rd_busy3;
  logic         wr_en3;
  logic [3:0]   wr_addr3;
  logic [31:0]  wr_data3;
  logic         iss_en3;
  logic [3:0]   iss_addr3;
  logic [15:0]  busy_vec3;

  int n_cmp = 0;
  int n_err = 0;

  legv8_regfile_sb u_dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec)
  );

  legv8_regfile_sb #(
    .DATA_W   (32),
    .NUM_REGS (16),
    .NUM_RD   (3),
    .ZERO_REG (15)
  ) u_dut3 (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr3),
    .rd_data  (rd_data3),
    .rd_busy  (rd_busy3),
    .wr_en    (wr_en3),
    .wr_addr  (wr_addr3),
    .wr_data  (wr_data3),
    .iss_en   (iss_en3),
    .iss_addr (iss_addr3),
    .busy_vec (busy_vec3)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    rd_addr  = '0; wr_en  = 1'b0; wr_addr  = '0; wr_data  = '0; iss_en  = 1'b0; iss_addr  = '0;
    rd_addr3 = '0; wr_en3 = 1'b0; wr_addr3 = '0; wr_data3 = '0; iss_en3 = 1'b0; iss_addr3 = '0;
    step();
    step();
    reset = 1'b0;

    // preload X5 and mark X4 busy, then let reset wipe both
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD;
    iss_en = 1'b1; iss_addr = 5'd4;
    step();
    wr_en = 1'b0; iss_en = 1'b0;
    rd_addr = {5'd4, 5'd5};
    #1;
    chk("pre_rst_x5", rd_data[63:0], 64'hDEAD);
    chk("pre_rst_busy", rd_busy, 2'b10);

    reset = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h77;
    iss_en = 1'b1; iss_addr = 5'd6;
    #1;
    chk("rst_comb_data", rd_data, 128'h0);
    chk("rst_comb_busy", rd_busy, 2'b00);
    step();
    step();
    reset = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
    rd_addr = {5'd4, 5'd5};
    #1;
    chk("rst_x5", rd_data, 128'h0);
    chk("rst_busy_vec", busy_vec, 32'h0);
    chk("rst_rd_busy", rd_busy, 2'b00);

    // basic write then read on both ports
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h0123_4567_89AB_CDEF;
    step();
    wr_en = 1'b0;
    rd_addr = {5'd3, 5'd3};
    #1;
    chk("basic_rd", rd_data, {2{64'h0123_4567_89AB_CDEF}});

    // same-cycle bypass
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h55;
    rd_addr = {5'd3, 5'd7};
    #1;
    chk("bypass_p0", rd_data[63:0], 64'h55);
    chk("bypass_p1_other", rd_data[127:64], 64'h0123_4567_89AB_CDEF);
    step();
    wr_en = 1'b0;
    rd_addr = {5'd7, 5'd7};
    #1;
    chk("stored_x7", rd_data, {2{64'h55}});

    // zero register ignores writes and never bypasses
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFF;
    rd_addr = {5'd31, 5'd31};
    #1;
    chk("xzr_bypass", rd_data, 128'h0);
    step();
    wr_en = 1'b0;
    #1;
    chk("xzr_read", rd_data, 128'h0);

    // scoreboard set / clear
    iss_en = 1'b1; iss_addr = 5'd9;
    rd_addr = {5'd9, 5'd9};
    #1;
    chk("iss_not_yet", rd_busy, 2'b00);
    step();
    iss_en = 1'b0;
    #1;
    chk("busy_set_vec", busy_vec, 32'h0000_0200);
    chk("busy_set_rd", rd_busy, 2'b11);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hAA;
    #1;
    chk("wb_rd_busy", rd_busy, 2'b00);
    chk("wb_bypass", rd_data, {2{64'hAA}});
    step();
    wr_en = 1'b0;
    #1;
    chk("busy_clr_vec", busy_vec, 32'h0);
    chk("x9_stored", rd_data, {2{64'hAA}});

    // issue and write-back to the same register: set wins
    iss_en = 1'b1; iss_addr = 5'd9;
    step();
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hBB;
    step();
    iss_en = 1'b0; wr_en = 1'b0;
    #1;
    chk("set_wins_vec", busy_vec, 32'h0000_0200);
    chk("set_wins_rd", rd_busy, 2'b11);
    chk("set_wins_data", rd_data, {2{64'hBB}});
    iss_en = 1'b1; iss_addr = 5'd31;
    step();
    iss_en = 1'b0;
    #1;
    chk("iss_xzr", busy_vec, 32'h0000_0200);

    // 32-bit / 16-register / 3-port build
    wr_en3 = 1'b1; wr_addr3 = 4'd2; wr_data3 = 32'hCAFE_BABE;
    rd_addr3 = {4'd2, 4'd2, 4'd2};
    #1;
    chk("p3_bypass", rd_data3, {3{32'hCAFE_BABE}});
    step();
    wr_en3 = 1'b0;
    #1;
    chk("p3_stored", rd_data3, {3{32'hCAFE_BABE}});
    iss_en3 = 1'b1; iss_addr3 = 4'd6;
    rd_addr3 = {4'd6, 4'd6, 4'd6};
    #1;
    chk("p3_iss_not_yet", rd_busy3, 3'b000);
    step();
    iss_en3 = 1'b0;
    #1;
    chk("p3_busy_vec", busy_vec3, 16'h0040);
    chk("p3_rd_busy", rd_busy3, 3'b111);
    wr_en3 = 1'b1; wr_addr3 = 4'd6; wr_data3 = 32'h1234_5678;
    #1;
    chk("p3_wb_busy", rd_busy3, 3'b000);
    chk("p3_wb_data", rd_data3, {3{32'h1234_5678}});
    step();
    wr_en3 = 1'b0;
    iss_en3 = 1'b1; iss_addr3 = 4'd15;
    step();
    iss_en3 = 1'b0;
    #1;
    chk("p3_iss_zero", busy_vec3, 16'h0000);
    rd_addr3 = {4'd15, 4'd6, 4'd2};
    #1;
    chk("p3_mixed", rd_data3, {32'h0, 32'h1234_5678, 32'hCAFE_BABE});
    wr_en3 = 1'b1; wr_addr3 = 4'd15; wr_data3 = 32'hFFFF_FFFF;
    #1;
    chk("p3_zero_bypass", rd_data3[95:64], 32'h0);
    step();
    wr_en3 = 1'b0;
    #1;
    chk("p3_zero_read", rd_data3[95:64], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
